pwm_cmd_tx: RTL
===============

// Module: pwm_cmd_tx
// PURPOSE
//   Host-side encoder for the PWM serial command protocol. Takes (channel, duty)
//   requests over a valid/ready handshake and emits the protocol bytes as 8N1 UART:
//   a channel-select byte {1,chan[6:0]}, then a duty byte {0,duty[7:1]}.
//   Drives a PWM controller board from another FPGA or a test harness. Holds its
//   own baud generator and shift register; it does not instantiate the uart core.
// PARAMETERS
//   CLK_FREQ  12000000  system clock frequency, Hz
//   BAUD      9600      line rate, bit/s; DIV = CLK_FREQ/BAUD clocks per bit (integer, >=2)
// PORTS
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   req_valid  in   1  request present
//   req_ready  out  1  block can accept a request
//   req_chan   in   7  target PWM channel
//   req_duty   in   8  target duty; bit 0 is dropped by the protocol
//   force_sel  in   1  always send the select byte for this request (sampled with request)
//   tx         out  1  serial line, idle high
//   busy       out  1  a frame is in progress or queued
//   sel_skipped out 1  1-cycle pulse at acceptance when the select byte is omitted
// BEHAVIOUR
// - Reset (async assert, sync release): tx=1, req_ready=1, busy=0, sel_skipped=0,
//   FSM=IDLE, baud/bit counters=0, channel cache invalid.
// - Handshake: accept when req_valid & req_ready on a rising clk edge. Latch chan,
//   duty and force_sel. req_ready drops the cycle after acceptance and stays low
//   until the transaction completes. req_* are don't-care while req_ready=0.
// - Select-byte elision: skip the select byte when all of these hold: cache valid,
//   req_chan == cached chan, force_sel=0. sel_skipped pulses in the cycle after
//   acceptance. Otherwise send the select byte, then update the cache to req_chan
//   and mark it valid. The cache updates at acceptance time.
// - FSM states: IDLE -> SEL (load {1,chan}) -> DUTY (load {0,duty[7:1]}) -> IDLE.
//   If select is skipped, go IDLE -> DUTY.
//   Each byte-load state runs a frame sub-sequence START -> DATA x8 -> STOP.
// - Frame: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly DIV
//   clocks. Frame = 10*DIV clocks. No gap between the select and duty frames.
// - Latency: tx falls (start bit) on the first clock edge after acceptance. Full
//   transaction = 20*DIV clocks (10*DIV if skipped).
//   At the end of the duty stop bit, the same edge returns the FSM to IDLE and sets
//   req_ready=1 and busy=0. A back-to-back request can be accepted on the next edge,
//   so the stop bit is never shortened.
// - busy = (FSM != IDLE). tx is registered, glitch-free, and held 1 in IDLE.
// - Counters: the baud counter counts 0..DIV-1 and wraps. The bit index counts 0..9
//   per frame and never exceeds 9.
// - Reset mid-frame: tx returns to 1 immediately, the partial frame is abandoned and
//   the cache is invalidated, so the next request always sends its select byte.
// - Channel 0 with duty 0x00 is a legal request: bytes 0x80, 0x00.
//   duty=0xFF sends 0x7F.
// TESTING  (bench uses CLK_FREQ=16, BAUD=1 -> DIV=16)
// 1 Reset, then request chan=3, duty=0x81 -> tx emits 0x83 then 0x40; each bit is 16
//   clocks; the start bit begins 1 clock after the handshake; req_ready returns after
//   320 clocks.
// 2 Repeat chan=3, duty=0x20 -> sel_skipped pulses; only 0x10 is sent; 160 clocks.
// 3 chan=3, duty=0x20, force_sel=1 -> 0x83, 0x10 sent; no sel_skipped pulse.
// 4 Hold req_valid high with chan 5 then chan 6 -> second request accepted exactly on
//   the cycle ready rises; the line is never idle less than one full stop bit;
//   bytes 0x85,0x..,0x86,0x..
// 5 Assert rst_n=0 during data bit 4 of the select byte -> tx=1 asynchronously; the
//   same channel as before sends its select byte on the next request.
// 6 Bench UART receiver decodes all frames with zero framing errors across random
//   (chan, duty) over 200 requests.

Source files
------------

// File: rtl/pwm_cmd_tx.sv
// Host-side encoder for the PWM serial command protocol: turns (channel, duty)
// requests into a select byte {1,chan} and a duty byte {0,duty[7:1]} on an 8N1 line.
module pwm_cmd_tx #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_chan,
  input  logic [7:0] req_duty,
  input  logic       force_sel,
  output logic       tx,
  output logic       busy,
  output logic       sel_skipped
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    DUTY = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] baud_reg, baud_next;
  logic [3:0]    bit_reg, bit_next;
  logic [7:0]    byte_reg, byte_next;
  logic [6:0]    duty_reg, duty_next;
  logic [6:0]    cache_chan_reg, cache_chan_next;
  logic          cache_valid_reg, cache_valid_next;
  logic          tx_reg, tx_next;
  logic          skip_reg, skip_next;
  logic          accept;
  logic          skip_sel;

  // Line level for frame position idx: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic line_level(input logic [3:0] idx, input logic [7:0] data);
    logic [3:0] d;
    d = idx - 4'd1;
    if (idx == 4'd0)      return 1'b0;
    else if (idx >= 4'd9) return 1'b1;
    else                  return data[d[2:0]];
  endfunction

  assign accept   = req_valid && (state_reg == IDLE);
  assign skip_sel = cache_valid_reg && (req_chan == cache_chan_reg) && !force_sel;

  always_comb begin
    state_next       = state_reg;
    baud_next        = baud_reg;
    bit_next         = bit_reg;
    byte_next        = byte_reg;
    duty_next        = duty_reg;
    cache_chan_next  = cache_chan_reg;
    cache_valid_next = cache_valid_reg;
    tx_next          = tx_reg;
    skip_next        = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          duty_next        = req_duty[7:1];
          cache_chan_next  = req_chan;
          cache_valid_next = 1'b1;
          baud_next        = '0;
          bit_next         = 4'd0;
          tx_next          = 1'b0;
          skip_next        = skip_sel;
          if (skip_sel) begin
            state_next = DUTY;
            byte_next  = {1'b0, req_duty[7:1]};
          end else begin
            state_next = SEL;
            byte_next  = {1'b1, req_chan};
          end
        end
      end
      default: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next = '0;
          if (bit_reg == 4'd9) begin
            bit_next = 4'd0;
            // Duty frame starts on the same edge the select stop bit ends: no gap.
            if (state_reg == SEL) begin
              state_next = DUTY;
              byte_next  = {1'b0, duty_reg};
              tx_next    = 1'b0;
            end else begin
              state_next = IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_reg + 4'd1;
            tx_next  = line_level(bit_reg + 4'd1, byte_reg);
          end
        end else begin
          baud_next = baud_reg + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      baud_reg        <= '0;
      bit_reg         <= 4'd0;
      byte_reg        <= 8'd0;
      duty_reg        <= 7'd0;
      cache_chan_reg  <= 7'd0;
      cache_valid_reg <= 1'b0;
      tx_reg          <= 1'b1;
      skip_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      baud_reg        <= baud_next;
      bit_reg         <= bit_next;
      byte_reg        <= byte_next;
      duty_reg        <= duty_next;
      cache_chan_reg  <= cache_chan_next;
      cache_valid_reg <= cache_valid_next;
      tx_reg          <= tx_next;
      skip_reg        <= skip_next;
    end
  end

  assign req_ready   = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign tx          = tx_reg;
  assign sel_skipped = skip_reg;

endmodule
